// File: rtl/teclado_pkg.sv
// Shared key and controller types for the keypad operand-capture path.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package teclado_pkg;

  // Decoded meaning of one keypad press.
  typedef enum logic [1:0] {
    DIGIT   = 2'd0,
    CLR     = 2'd1,
    ENT     = 2'd2,
    INVALID = 2'd3
  } key_kind_t;

  // Operand-capture sequencing states.
  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    PRESENT = 2'd2
  } ctrl_state_t;

  // Columns c0..c2 carry keys; the fourth column is not populated.
  localparam int KEY_COLS_USED = 3;
  // Row r3 holds the command keys (* 0 #); rows above it are plain digits.
  localparam int KEY_ROW_CMD   = 3;

endpackage

// File: rtl/decodificador_tecla.sv
// Maps a one-hot (col,row) keypad position to a key kind and digit value.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the decoded key is consumed.
module decodificador_tecla
  import teclado_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] key_col,
  input  logic [WIDTH-1:0] key_row,
  output key_kind_t        kind,
  output logic [3:0]       digit
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [IDX_W-1:0] w_col_idx;
  logic [IDX_W-1:0] w_row_idx;
  logic             w_col_ok;
  logic             w_row_ok;

  // Index of the set bit, counted from the MSB (MSB is c0 / r0).
  always_comb begin
    w_col_idx = '0;
    w_row_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (key_col[WIDTH-1-i]) w_col_idx = IDX_W'(i);
      if (key_row[WIDTH-1-i]) w_row_idx = IDX_W'(i);
    end
  end

  // A position is only meaningful when both vectors are one-hot and inside the populated grid.
  assign w_col_ok = $onehot(key_col) && (int'(w_col_idx) < KEY_COLS_USED);
  assign w_row_ok = $onehot(key_row) && (int'(w_row_idx) <= KEY_ROW_CMD);

  // Rows r0..r2 are digits 1..9 laid out row-major; r3 is CLR, 0, ENT.
  always_comb begin
    kind  = INVALID;
    digit = 4'd0;
    if (w_col_ok && w_row_ok) begin
      if (int'(w_row_idx) < KEY_ROW_CMD) begin
        kind  = DIGIT;
        digit = 4'(w_row_idx) * 4'd3 + 4'(w_col_idx) + 4'd1;
      end else begin
        case (int'(w_col_idx))
          0:       kind = CLR;
          1:       kind = DIGIT;
          default: kind = ENT;
        endcase
      end
    end
  end

endmodule

// File: rtl/captura_operandos.sv
// Captures two decimal operands from keypad events and hands the pair downstream.
// Latency: key effects and key_ack one cycle after consumption; ops_valid one cycle after ENT of B.
// Backpressure: no key is consumed while the pair waits for ops_ready. Optional KEYPAD_TIMEOUT_EN.
module captura_operandos
  import teclado_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int MAX_DIGITS     = 3,
  parameter int OP_WIDTH       = 10,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic [WIDTH-1:0]    key_col,
  input  logic [WIDTH-1:0]    key_row,
  output logic                key_ack,
  output logic [OP_WIDTH-1:0] op_a,
  output logic [OP_WIDTH-1:0] op_b,
  output logic                ops_valid,
  input  logic                ops_ready,
  output logic [OP_WIDTH-1:0] entry_value,
  output logic                entry_sel,
  output logic                key_error,
  output logic                timeout
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  // Refuse to elaborate a configuration whose operand cannot hold the largest entry.
  if (TIMEOUT_CYCLES < 1 || OP_WIDTH < $clog2(10**MAX_DIGITS)) begin : g_cfg_check
    $error("captura_operandos: operand width or timeout parameter out of range");
  end

  ctrl_state_t         r_state;
  ctrl_state_t         w_nxt_state;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_nxt_count;
  logic [CNT_W-1:0]    r_digits_a;
  logic [CNT_W-1:0]    w_nxt_digits_a;
  logic [OP_WIDTH-1:0] r_entry;
  logic [OP_WIDTH-1:0] w_nxt_entry;
  logic [OP_WIDTH-1:0] r_op_a;
  logic [OP_WIDTH-1:0] w_nxt_op_a;
  logic [OP_WIDTH-1:0] r_op_b;
  logic [OP_WIDTH-1:0] w_nxt_op_b;
  logic                r_ops_valid;
  logic                w_nxt_ops_valid;
  logic                r_key_ack;
  logic                w_nxt_key_ack;
  logic                r_key_error;
  logic                w_nxt_key_error;
  logic                r_timeout;
  logic                w_nxt_timeout;

  key_kind_t           w_kind;
  logic [3:0]          w_digit;
  logic                w_consume;
  logic                w_handshake;
  logic                w_tmo_fire;

  decodificador_tecla #(
    .WIDTH (WIDTH)
  ) u_decodificador_tecla (
    .key_col (key_col),
    .key_row (key_row),
    .kind    (w_kind),
    .digit   (w_digit)
  );

  // The ack register blocks re-consuming the same key while the reader is still dropping key_valid.
  assign w_consume   = key_valid && !r_key_ack && (r_state != PRESENT);
  assign w_handshake = (r_state == PRESENT) && r_ops_valid && ops_ready;

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_idle;
  logic             w_idle_run;

  // Inactivity only matters once something has been typed; an empty A entry never times out.
  assign w_idle_run = (r_state == ENTRY_B) || ((r_state == ENTRY_A) && (r_count != '0));
  assign w_tmo_fire = w_idle_run && !w_consume && (r_idle == TMO_W'(TIMEOUT_CYCLES - 1));

  // Inactivity counter: cleared by any consumed key, by leaving the active states, and on firing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (w_consume || !w_idle_run || w_tmo_fire) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + TMO_W'(1);
    end
  end
`else
  assign w_tmo_fire = 1'b0;
`endif

  // Next-state and datapath decisions; a consumed key takes priority over the timeout.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_count     = r_count;
    w_nxt_digits_a  = r_digits_a;
    w_nxt_entry     = r_entry;
    w_nxt_op_a      = r_op_a;
    w_nxt_op_b      = r_op_b;
    w_nxt_ops_valid = r_ops_valid;
    w_nxt_key_ack   = 1'b0;
    w_nxt_key_error = 1'b0;
    w_nxt_timeout   = 1'b0;

    if (w_consume) begin
      w_nxt_key_ack = 1'b1;
      case (w_kind)
        DIGIT: begin
          if (r_count < CNT_W'(MAX_DIGITS)) begin
            w_nxt_entry = r_entry * OP_WIDTH'(10) + OP_WIDTH'(w_digit);
            w_nxt_count = r_count + CNT_W'(1);
          end else begin
            w_nxt_key_error = 1'b1;
          end
        end
        CLR: begin
          if (r_count != '0) begin
            w_nxt_entry = '0;
            w_nxt_count = '0;
          end else if (r_state == ENTRY_B) begin
            // Backing out of an empty B reopens A for editing with its digits intact.
            w_nxt_state = ENTRY_A;
            w_nxt_entry = r_op_a;
            w_nxt_count = r_digits_a;
          end
        end
        ENT: begin
          if (r_count == '0) begin
            w_nxt_key_error = 1'b1;
          end else if (r_state == ENTRY_A) begin
            w_nxt_op_a     = r_entry;
            w_nxt_digits_a = r_count;
            w_nxt_state    = ENTRY_B;
            w_nxt_entry    = '0;
            w_nxt_count    = '0;
          end else begin
            w_nxt_op_b      = r_entry;
            w_nxt_state     = PRESENT;
            w_nxt_ops_valid = 1'b1;
          end
        end
        default: begin
          w_nxt_key_error = 1'b1;
        end
      endcase
    end else if (w_handshake) begin
      w_nxt_ops_valid = 1'b0;
      w_nxt_state     = ENTRY_A;
      w_nxt_entry     = '0;
      w_nxt_count     = '0;
    end else if (w_tmo_fire) begin
      w_nxt_state    = ENTRY_A;
      w_nxt_entry    = '0;
      w_nxt_count    = '0;
      w_nxt_op_a     = '0;
      w_nxt_digits_a = '0;
      w_nxt_timeout  = 1'b1;
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ENTRY_A;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Operand accumulator, captured operands and single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_digits_a  <= '0;
      r_entry     <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_ops_valid <= 1'b0;
      r_key_ack   <= 1'b0;
      r_key_error <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_count     <= w_nxt_count;
      r_digits_a  <= w_nxt_digits_a;
      r_entry     <= w_nxt_entry;
      r_op_a      <= w_nxt_op_a;
      r_op_b      <= w_nxt_op_b;
      r_ops_valid <= w_nxt_ops_valid;
      r_key_ack   <= w_nxt_key_ack;
      r_key_error <= w_nxt_key_error;
      r_timeout   <= w_nxt_timeout;
    end
  end

  assign key_ack     = r_key_ack;
  assign op_a        = r_op_a;
  assign op_b        = r_op_b;
  assign ops_valid   = r_ops_valid;
  assign entry_value = r_entry;
  assign entry_sel   = (r_state == ENTRY_B);
  assign key_error   = r_key_error;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_captura_operandos.sv
// Bench for captura_operandos: directed scenarios plus random key streams against a digit-list model.
// Latency: checks sample #1 after the rising edge.
// Backpressure: exercises held ops_ready with a pending key.
module tb_captura_operandos;

  localparam int MAXD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_col = 4'd0;
  logic [3:0] key_row = 4'd0;
  logic       ops_ready = 1'b0;
  logic       key_ack;
  logic [9:0] op_a;
  logic [9:0] op_b;
  logic       ops_valid;
  logic [9:0] entry_value;
  logic       entry_sel;
  logic       key_error;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the operand being typed is the list of digits entered so far.
  int m_digs[$];
  int m_a_digs[$];
  bit m_sel;
  bit m_present;
  int m_op_a;
  int m_op_b;

  localparam logic [7:0] K_CLR = {4'b1000, 4'b0001};
  localparam logic [7:0] K_ENT = {4'b0010, 4'b0001};

  captura_operandos #(
    .WIDTH          (4),
    .MAX_DIGITS     (MAXD),
    .OP_WIDTH       (10),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_col     (key_col),
    .key_row     (key_row),
    .key_ack     (key_ack),
    .op_a        (op_a),
    .op_b        (op_b),
    .ops_valid   (ops_valid),
    .ops_ready   (ops_ready),
    .entry_value (entry_value),
    .entry_sel   (entry_sel),
    .key_error   (key_error),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc_digit(input int d);
    logic [3:0] c;
    logic [3:0] r;
    int k;
    if (d == 0) begin
      c = 4'b0100;
      r = 4'b0001;
    end else begin
      k = d - 1;
      r = 4'b1000 >> (k / 3);
      c = 4'b1000 >> (k % 3);
    end
    return {c, r};
  endfunction

  function automatic int m_val();
    int v = 0;
    foreach (m_digs[i]) v = v * 10 + m_digs[i];
    return v;
  endfunction

  // kind: 0 digit, 1 clear, 2 enter, 3 invalid. Returns the expected error pulse.
  function automatic bit m_apply(input int kind, input int d);
    bit err = 1'b0;
    case (kind)
      0: if (m_digs.size() < MAXD) m_digs.push_back(d); else err = 1'b1;
      1: begin
        if (m_digs.size() > 0) m_digs.delete();
        else if (m_sel) begin m_sel = 1'b0; m_digs = m_a_digs; end
      end
      2: begin
        if (m_digs.size() == 0) err = 1'b1;
        else if (!m_sel) begin
          m_op_a = m_val(); m_a_digs = m_digs; m_digs.delete(); m_sel = 1'b1;
        end else begin
          m_op_b = m_val(); m_present = 1'b1; m_digs.delete();
        end
      end
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Offer one key and wait (bounded) for its ack; returns at #1 after the ack edge.
  task automatic press(input logic [7:0] cr, output bit ok);
    @(negedge clk);
    key_col   = cr[7:4];
    key_row   = cr[3:0];
    key_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (key_ack === 1'b1) ok = 1'b1;
    end
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ops_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ops_valid got=%b want=0", ops_valid); end
    n_checks++; if (op_a !== 10'd0) begin n_errors++; $display("FAIL reset_op_a got=%0d want=0", op_a); end
    n_checks++; if (op_b !== 10'd0) begin n_errors++; $display("FAIL reset_op_b got=%0d want=0", op_b); end
    n_checks++; if (entry_value !== 10'd0) begin n_errors++; $display("FAIL reset_entry got=%0d want=0", entry_value); end
    n_checks++; if (entry_sel !== 1'b0) begin n_errors++; $display("FAIL reset_entry_sel got=%b want=0", entry_sel); end
    n_checks++; if (key_ack !== 1'b0 || key_error !== 1'b0 || timeout !== 1'b0) begin
      n_errors++; $display("FAIL reset_pulses got ack=%b err=%b tmo=%b want all 0", key_ack, key_error, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (key_ack !== 1'b0 || entry_sel !== 1'b0) begin
      n_errors++; $display("FAIL reset_release got ack=%b sel=%b want 0 0", key_ack, entry_sel);
    end
  endtask

  task automatic test_basic();
    logic [7:0] seq[6];
    int exp_v[6];
    bit ok;
    seq = '{enc_digit(1), enc_digit(2), K_ENT, enc_digit(3), enc_digit(4), enc_digit(5)};
    exp_v = '{1, 12, 0, 3, 34, 345};
    for (int i = 0; i < 6; i++) begin
      press(seq[i], ok);
      n_checks++;
      if (!ok || key_error !== 1'b0 || entry_value !== 10'(exp_v[i])) begin
        n_errors++;
        $display("FAIL basic_key%0d got ack=%b err=%b entry=%0d want ack=1 err=0 entry=%0d", i, ok, key_error, entry_value, exp_v[i]);
      end
    end
    n_checks++; if (op_a !== 10'd12 || entry_sel !== 1'b1) begin
      n_errors++; $display("FAIL basic_op_a got op_a=%0d sel=%b want 12 1", op_a, entry_sel);
    end
    ops_ready = 1'b1;
    press(K_ENT, ok);
    n_checks++; if (!ok || ops_valid !== 1'b1 || op_a !== 10'd12 || op_b !== 10'd345) begin
      n_errors++; $display("FAIL basic_present got ack=%b vld=%b a=%0d b=%0d want 1 1 12 345", ok, ops_valid, op_a, op_b);
    end
    @(posedge clk);
    #1;
    ops_ready = 1'b0;
    n_checks++; if (ops_valid !== 1'b0 || entry_sel !== 1'b0 || entry_value !== 10'd0 || key_ack !== 1'b0) begin
      n_errors++; $display("FAIL basic_handshake got vld=%b sel=%b entry=%0d ack=%b want 0 0 0 0", ops_valid, entry_sel, entry_value, key_ack);
    end
  endtask

  task automatic test_overflow();
    int exp_v[4];
    bit exp_e[4];
    bit ok;
    exp_v = '{9, 99, 999, 999};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      press(enc_digit(9), ok);
      n_checks++;
      if (!ok || key_error !== exp_e[i] || entry_value !== 10'(exp_v[i])) begin
        n_errors++;
        $display("FAIL overflow_key%0d got ack=%b err=%b entry=%0d want ack=1 err=%b entry=%0d", i, ok, key_error, entry_value, exp_e[i], exp_v[i]);
      end
    end
    @(posedge clk);
    #1;
    n_checks++; if (key_error !== 1'b0 || key_ack !== 1'b0) begin
      n_errors++; $display("FAIL overflow_pulse_width got err=%b ack=%b want 0 0", key_error, key_ack);
    end
    press(K_CLR, ok);
    n_checks++; if (!ok || entry_value !== 10'd0) begin
      n_errors++; $display("FAIL overflow_clr got ack=%b entry=%0d want 1 0", ok, entry_value);
    end
  endtask

  task automatic test_edit_a();
    bit ok;
    press(enc_digit(7), ok);
    press(K_ENT, ok);
    n_checks++; if (entry_sel !== 1'b1 || op_a !== 10'd7) begin
      n_errors++; $display("FAIL edit_enter_a got sel=%b op_a=%0d want 1 7", entry_sel, op_a);
    end
    press(K_CLR, ok);
    n_checks++; if (!ok || entry_sel !== 1'b0 || entry_value !== 10'd7 || key_error !== 1'b0) begin
      n_errors++; $display("FAIL edit_back got ack=%b sel=%b entry=%0d err=%b want 1 0 7 0", ok, entry_sel, entry_value, key_error);
    end
    press(enc_digit(8), ok);
    press(K_ENT, ok);
    press(enc_digit(5), ok);
    press(K_ENT, ok);
    n_checks++; if (op_a !== 10'd78 || op_b !== 10'd5 || ops_valid !== 1'b1) begin
      n_errors++; $display("FAIL edit_result got a=%0d b=%0d vld=%b want 78 5 1", op_a, op_b, ops_valid);
    end
    @(negedge clk);
    ops_ready = 1'b1;
    @(posedge clk);
    #1;
    ops_ready = 1'b0;
    n_checks++; if (ops_valid !== 1'b0 || entry_sel !== 1'b0) begin
      n_errors++; $display("FAIL edit_handshake got vld=%b sel=%b want 0 0", ops_valid, entry_sel);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] k4;
    press(enc_digit(1), ok);
    press(K_ENT, ok);
    press(enc_digit(2), ok);
    press(K_ENT, ok);
    k4 = enc_digit(4);
    @(negedge clk);
    key_col = k4[7:4];
    key_row = k4[3:0];
    key_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (key_ack !== 1'b0 || ops_valid !== 1'b1 || op_a !== 10'd1 || op_b !== 10'd2) begin
        n_errors++; $display("FAIL bp_hold_c%0d got ack=%b vld=%b a=%0d b=%0d want 0 1 1 2", i, key_ack, ops_valid, op_a, op_b);
      end
    end
    @(negedge clk);
    ops_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (ops_valid !== 1'b0 || key_ack !== 1'b0) begin
      n_errors++; $display("FAIL bp_handshake got vld=%b ack=%b want 0 0", ops_valid, key_ack);
    end
    @(negedge clk);
    ops_ready = 1'b0;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    n_checks++; if (key_ack !== 1'b1 || entry_value !== 10'd4 || entry_sel !== 1'b0) begin
      n_errors++; $display("FAIL bp_pending_key got ack=%b entry=%0d sel=%b want 1 4 0", key_ack, entry_value, entry_sel);
    end
    press(K_CLR, ok);
  endtask

  task automatic test_invalid();
    logic [7:0] bad[4];
    bit ok;
    bad = '{8'b0001_1000, 8'b1000_1100, 8'b0000_0000, 8'b0110_0100};
    press(enc_digit(3), ok);
    for (int i = 0; i < 4; i++) begin
      press(bad[i], ok);
      n_checks++;
      if (!ok || key_error !== 1'b1 || entry_value !== 10'd3 || entry_sel !== 1'b0) begin
        n_errors++; $display("FAIL invalid_%0d got ack=%b err=%b entry=%0d sel=%b want 1 1 3 0", i, ok, key_error, entry_value, entry_sel);
      end
    end
    press(K_CLR, ok);
    press(K_ENT, ok);
    n_checks++; if (!ok || key_error !== 1'b1 || entry_sel !== 1'b0 || entry_value !== 10'd0) begin
      n_errors++; $display("FAIL invalid_empty_ent_a got ack=%b err=%b sel=%b entry=%0d want 1 1 0 0", ok, key_error, entry_sel, entry_value);
    end
    press(enc_digit(6), ok);
    press(K_ENT, ok);
    press(K_ENT, ok);
    n_checks++; if (key_error !== 1'b1 || entry_sel !== 1'b1 || ops_valid !== 1'b0) begin
      n_errors++; $display("FAIL invalid_empty_ent_b got err=%b sel=%b vld=%b want 1 1 0", key_error, entry_sel, ops_valid);
    end
    press(K_CLR, ok);
    press(K_CLR, ok);
    n_checks++; if (entry_value !== 10'd0 || entry_sel !== 1'b0) begin
      n_errors++; $display("FAIL invalid_cleanup got entry=%0d sel=%b want 0 0", entry_value, entry_sel);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit exp_err;
    int r;
    int kind;
    int d;
    int hold;
    logic [7:0] cr;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_digs.delete();
    m_a_digs.delete();
    m_sel = 1'b0;
    m_present = 1'b0;
    m_op_a = 0;
    m_op_b = 0;
    for (int it = 0; it < 300; it++) begin
      if (m_present) begin
        hold = $urandom_range(0, 4);
        for (int h = 0; h < hold; h++) begin
          @(posedge clk);
          #1;
          n_checks++;
          if (ops_valid !== 1'b1 || op_a !== 10'(m_op_a) || op_b !== 10'(m_op_b)) begin
            n_errors++; $display("FAIL rnd_hold_it%0d got vld=%b a=%0d b=%0d want 1 %0d %0d", it, ops_valid, op_a, op_b, m_op_a, m_op_b);
          end
        end
        @(negedge clk);
        ops_ready = 1'b1;
        @(posedge clk);
        #1;
        ops_ready = 1'b0;
        m_present = 1'b0;
        m_sel = 1'b0;
        m_digs.delete();
        n_checks++;
        if (ops_valid !== 1'b0 || entry_value !== 10'd0 || entry_sel !== 1'b0) begin
          n_errors++; $display("FAIL rnd_handshake_it%0d got vld=%b entry=%0d sel=%b want 0 0 0", it, ops_valid, entry_value, entry_sel);
        end
      end
      r = $urandom_range(0, 99);
      d = $urandom_range(0, 9);
      if (r < 60) begin
        kind = 0; cr = enc_digit(d);
      end else if (r < 75) begin
        kind = 2; cr = K_ENT;
      end else if (r < 88) begin
        kind = 1; cr = K_CLR;
      end else begin
        kind = 3;
        case ($urandom_range(0, 3))
          0:       cr = {4'b0001, 4'b1000 >> $urandom_range(0, 3)};
          1:       cr = {4'b1000, 4'b1100};
          2:       cr = {4'b0000, 4'b0100};
          default: cr = {4'b1100, 4'b0010};
        endcase
      end
      ops_ready = 1'($urandom_range(0, 1));
      exp_err = m_apply(kind, d);
      press(cr, ok);
      ops_ready = 1'b0;
      n_checks++;
      if (!ok || key_error !== exp_err || ops_valid !== m_present || op_a !== 10'(m_op_a) || op_b !== 10'(m_op_b)) begin
        n_errors++;
        $display("FAIL rnd_key_it%0d kind=%0d got ack=%b err=%b vld=%b a=%0d b=%0d want 1 %b %b %0d %0d",
                 it, kind, ok, key_error, ops_valid, op_a, op_b, exp_err, m_present, m_op_a, m_op_b);
      end
      if (!m_present) begin
        n_checks++;
        if (entry_value !== 10'(m_val()) || entry_sel !== m_sel) begin
          n_errors++; $display("FAIL rnd_entry_it%0d got entry=%0d sel=%b want %0d %b", it, entry_value, entry_sel, m_val(), m_sel);
        end
      end
    end
    if (m_present) begin
      @(negedge clk);
      ops_ready = 1'b1;
      @(posedge clk);
      #1;
      ops_ready = 1'b0;
    end
  endtask

  task automatic test_reset_present();
    bit ok;
    press(enc_digit(4), ok);
    press(K_ENT, ok);
    press(enc_digit(5), ok);
    press(K_ENT, ok);
    n_checks++; if (ops_valid !== 1'b1) begin
      n_errors++; $display("FAIL rstp_setup got vld=%b want 1", ops_valid);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ops_valid !== 1'b0 || op_a !== 10'd0 || op_b !== 10'd0 || entry_value !== 10'd0) begin
      n_errors++; $display("FAIL rstp_async got vld=%b a=%0d b=%0d entry=%0d want 0 0 0 0", ops_valid, op_a, op_b, entry_value);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    int at;
    press(enc_digit(5), ok);
    seen = 1'b0;
    at = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (timeout === 1'b1 && !seen) begin seen = 1'b1; at = i; end
    end
`ifdef KEYPAD_TIMEOUT_EN
    n_checks++; if (!seen || at < 14 || at > 18) begin
      n_errors++; $display("FAIL timeout_pulse got seen=%b at=%0d want pulse near cycle 16", seen, at);
    end
    n_checks++; if (entry_value !== 10'd0 || op_a !== 10'd0 || entry_sel !== 1'b0) begin
      n_errors++; $display("FAIL timeout_clear got entry=%0d a=%0d sel=%b want 0 0 0", entry_value, op_a, entry_sel);
    end
`else
    n_checks++; if (seen || entry_value !== 10'd5) begin
      n_errors++; $display("FAIL timeout_off got tmo_seen=%b entry=%0d want 0 5", seen, entry_value);
    end
    press(K_CLR, ok);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_edit_a();
    test_backpressure();
    test_invalid();
    test_timeout();
    test_random();
    test_reset_present();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
